// File: rtl/reg_bank_arbiter_pkg.sv
// reg_bank_arbiter_pkg: shared state encoding and round-robin pick for the register bank arbiter
package reg_bank_arbiter_pkg;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_CLEAR  = 2'd2;
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr, input logic [3:0] n);
    logic [3:0] idx;
    rr_pick = ptr;
    for (int i = 7; i >= 0; i--) begin
      idx = ({1'b0, ptr} + 4'(i)) % n;
      if (4'(i) < n && req[idx[2:0]]) rr_pick = idx[2:0];
    end
  endfunction
endpackage

// File: rtl/reg_bank_arbiter_reg_bank.sv
// reg_bank: NREG x DW flop words with write port, per-entry synchronous clear and combinational read
module reg_bank #(
  parameter int DW   = 8,
  parameter int NREG = 4,
  parameter int AW   = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          clr,
  input  logic [AW-1:0] clr_idx,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] regs [NREG];
  always_ff @(posedge clk or negedge rst)
    if (!rst)
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    else
      for (int i = 0; i < NREG; i++)
        if (clr && clr_idx == AW'(i)) regs[i] <= '0;
        else if (we && addr == AW'(i)) regs[i] <= wdata;
  // addresses past NREG match no entry, so they read 0 and writes vanish
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NREG; i++) if (addr == AW'(i)) rdata = regs[i];
  end
endmodule

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: round-robin access arbiter and sequenced clear for a shared register bank
module reg_bank_arbiter
  import reg_bank_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int NREG = 4,
  parameter int AW   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  input  logic             clr_req,
  output logic [NREQ-1:0]  gnt,
  output logic [DW-1:0]    rdata,
  output logic             busy,
  output logic             clr_done
);
  logic [1:0] state, state_n;
  logic [2:0] rr_ptr, win, pick;
  logic lat_we, sel_we, clr_pending, last;
  logic [AW-1:0] lat_addr, sel_addr, clr_idx;
  logic [DW-1:0] lat_wdata, sel_wdata, rdata_q, bank_rdata;
  assign pick = rr_pick(8'(req), rr_ptr, 4'(NREQ));
  assign last = clr_idx == AW'(NREG - 1);
  always_comb begin
    sel_we = 1'b0;
    sel_addr = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++)
      if (pick == 3'(i)) begin
        sel_we = req_we[i];
        sel_addr = req_addr[i*AW +: AW];
        sel_wdata = req_wdata[i*DW +: DW];
      end
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= ST_IDLE;
    else state <= state_n;
  // a pending or fresh clear always wins over requests
  always_comb
    state_n = state == ST_IDLE ? ((clr_pending || clr_req) ? ST_CLEAR : |req ? ST_ACCESS : ST_IDLE)
            : (state == ST_CLEAR && !last) ? ST_CLEAR : ST_IDLE;
  always_comb begin
    gnt = '0;
    for (int i = 0; i < NREQ; i++) gnt[i] = state == ST_ACCESS && win == 3'(i);
    busy = state != ST_IDLE || clr_pending;
    rdata = (state == ST_ACCESS && !lat_we) ? bank_rdata : rdata_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rr_ptr <= '0;
      win <= '0;
      lat_we <= 1'b0;
      lat_addr <= '0;
      lat_wdata <= '0;
      clr_pending <= 1'b0;
      clr_idx <= '0;
      clr_done <= 1'b0;
      rdata_q <= '0;
    end else begin
      // only ACCESS can leave a clear waiting; IDLE consumes it and CLEAR absorbs repeats
      clr_pending <= state == ST_ACCESS && (clr_pending || clr_req);
      clr_done <= state == ST_CLEAR && last;
      clr_idx <= (state == ST_CLEAR && !last) ? clr_idx + 1'b1 : '0;
      rdata_q <= rdata;
      if (state == ST_IDLE && state_n == ST_ACCESS) begin
        win <= pick;
        lat_we <= sel_we;
        lat_addr <= sel_addr;
        lat_wdata <= sel_wdata;
      end
      if (state == ST_ACCESS) rr_ptr <= win == 3'(NREQ - 1) ? 3'd0 : win + 3'd1;
    end
  reg_bank #(.DW(DW), .NREG(NREG), .AW(AW)) u_bank (
    .clk(clk),
    .rst(rst),
    .we(state == ST_ACCESS && lat_we),
    .addr(lat_addr),
    .wdata(lat_wdata),
    .clr(state == ST_CLEAR),
    .clr_idx(clr_idx),
    .rdata(bank_rdata)
  );
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter: table, directed and randomized checks of reg_bank_arbiter
module tb_reg_bank_arbiter;
  logic clk = 1'b0, rst = 1'b0, rst3 = 1'b0, clr_req = 1'b0, sel3 = 1'b0;
  logic [3:0] req = '0, req_we = '0;
  logic [7:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0] gnt, gnt3, g_obs;
  logic [7:0] rdata, rdata3, r_obs;
  logic busy, busy3, clr_done, clr_done3;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  assign g_obs = sel3 ? gnt3 : gnt;
  assign r_obs = sel3 ? rdata3 : rdata;

  reg_bank_arbiter #(.NREQ(4), .DW(8), .NREG(4), .AW(2)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .clr_req(clr_req), .gnt(gnt), .rdata(rdata),
    .busy(busy), .clr_done(clr_done));
  reg_bank_arbiter #(.NREQ(4), .DW(8), .NREG(3), .AW(2)) dut3 (
    .clk(clk), .rst(rst3), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .clr_req(clr_req), .gnt(gnt3), .rdata(rdata3),
    .busy(busy3), .clr_done(clr_done3));

  typedef struct {int r; logic we; logic [1:0] a; logic [7:0] d; logic [3:0] eg; logic [7:0] erd;} vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic set_req(input int r, input logic we, input logic [1:0] a, input logic [7:0] d);
    req[r] = 1'b1;
    req_we[r] = we;
    req_addr[r*2 +: 2] = a;
    req_wdata[r*8 +: 8] = d;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    clr_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // returns at the negedge of the grant cycle; clr_req is dropped after one edge
  task automatic wait_gnt(output logic [3:0] g, output logic [7:0] rd, output bit done);
    g = '0;
    rd = '0;
    done = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (clr_done) done = 1'b1;
      if (g_obs != 0) begin
        g = g_obs;
        rd = r_obs;
        break;
      end
      @(posedge clk);
      #1 clr_req = 1'b0;
    end
    if (g == 0) begin
      total++;
      $display("FAIL gnt_timeout: got no grant within 16 cycles");
    end
  endtask

  task automatic txn(input string name, input int r, input logic we, input logic [1:0] a,
                     input logic [7:0] d, input logic [7:0] erd);
    logic [3:0] g;
    logic [7:0] rd;
    bit done;
    set_req(r, we, a, d);
    wait_gnt(g, rd, done);
    chk({name, "_gnt"}, 32'(g), 32'(1) << r);
    if (!we) chk({name, "_rd"}, 32'(rd), 32'(erd));
    @(posedge clk);
    #1 req[r] = 1'b0;
  endtask

  initial begin
    vec_t tbl[7];
    logic [3:0] g;
    logic [7:0] rd;
    bit done;
    int mdl[4];
    int ptr, cnt, j;
    logic [3:0] mask, pend;
    logic we_v[4];
    logic [1:0] a_v[4];
    logic [7:0] d_v[4];
    bit doclr, first;
    logic [3:0] eg3[6] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'b0001};
    logic eb3[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic ed3[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    tbl[0] = '{1, 1'b1, 2'd2, 8'hA5, 4'b0010, 8'h00};
    tbl[1] = '{1, 1'b0, 2'd2, 8'h00, 4'b0010, 8'hA5};
    tbl[2] = '{0, 1'b1, 2'd0, 8'h3C, 4'b0001, 8'hA5};
    tbl[3] = '{3, 1'b1, 2'd3, 8'hC3, 4'b1000, 8'hA5};
    tbl[4] = '{2, 1'b0, 2'd0, 8'h00, 4'b0100, 8'h3C};
    tbl[5] = '{3, 1'b0, 2'd3, 8'h00, 4'b1000, 8'hC3};
    tbl[6] = '{0, 1'b0, 2'd1, 8'h00, 4'b0001, 8'h00};

    do_reset();
    @(negedge clk);
    chk("reset_gnt", 32'(gnt), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(clr_done), 0);
    chk("reset_rdata", 32'(rdata), 0);
    @(posedge clk);
    #1;
    // fixed-latency single transactions
    for (int i = 0; i < 7; i++) begin
      set_req(tbl[i].r, tbl[i].we, tbl[i].a, tbl[i].d);
      @(negedge clk);
      chk("tbl_early_gnt", 32'(gnt), 0);
      @(posedge clk);
      @(negedge clk);
      chk("tbl_gnt", 32'(gnt), 32'(tbl[i].eg));
      chk("tbl_rdata", 32'(rdata), 32'(tbl[i].erd));
      @(posedge clk);
      #1 req = '0;
      @(negedge clk);
      chk("tbl_rdata_hold", 32'(rdata), 32'(tbl[i].erd));
      @(posedge clk);
      #1;
    end

    // round-robin with all requests held from rr_ptr=0
    do_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 2'd0, 8'h00);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("rr_gnt", 32'(gnt), (k % 2 == 1) ? (32'(1) << (((k - 1) / 2) % 4)) : 0);
      @(posedge clk);
      #1;
    end
    req = '0;

    // clear beats a simultaneous request
    do_reset();
    @(posedge clk);
    #1;
    txn("c3_w0", 0, 1'b1, 2'd0, 8'h11, 8'h00);
    txn("c3_w1", 1, 1'b1, 2'd1, 8'h22, 8'h00);
    txn("c3_w2", 2, 1'b1, 2'd2, 8'h33, 8'h00);
    txn("c3_w3", 3, 1'b1, 2'd3, 8'h44, 8'h00);
    set_req(0, 1'b0, 2'd3, 8'h00);
    clr_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1 clr_req = 1'b0;
      @(negedge clk);
      chk("c3_busy", 32'(busy), 32'(eb3[k]));
      chk("c3_done", 32'(clr_done), 32'(ed3[k]));
      chk("c3_gnt", 32'(gnt), 32'(eg3[k]));
    end
    chk("c3_rdata", 32'(rdata), 0);
    @(posedge clk);
    #1 req = '0;

    // clear requested during an ACCESS cycle
    set_req(1, 1'b1, 2'd1, 8'h77);
    @(posedge clk);
    #1 clr_req = 1'b1;
    @(negedge clk);
    chk("c4_gnt", 32'(gnt), 32'b0010);
    @(posedge clk);
    #1 begin clr_req = 1'b0; req = '0; end
    @(negedge clk);
    chk("c4_pending_busy", 32'(busy), 1);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (clr_done) cnt++;
    end
    chk("c4_clr_done_count", 32'(cnt), 1);
    @(posedge clk);
    #1;
    txn("c4_rd1", 1, 1'b0, 2'd1, 8'h00, 8'h00);

    // reset in the second CLEAR cycle
    txn("c5_w", 2, 1'b1, 2'd2, 8'h5A, 8'h00);
    clr_req = 1'b1;
    @(posedge clk);
    #1 clr_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("c5_gnt", 32'(gnt), 0);
    chk("c5_busy", 32'(busy), 0);
    chk("c5_done", 32'(clr_done), 0);
    @(posedge clk);
    #1 rst = 1'b1;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (clr_done || busy) cnt++;
    end
    chk("c5_quiet", 32'(cnt), 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 2'd0, 8'h00);
    wait_gnt(g, rd, done);
    chk("c5_first_gnt", 32'(g), 32'b0001);
    @(posedge clk);
    #1 req = '0;
    for (int i = 0; i < 4; i++) txn("c5_rd", 0, 1'b0, 2'(i), 8'h00, 8'h00);

    // randomized rounds against a transaction-level model
    do_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) mdl[i] = 0;
    ptr = 0;
    for (int rnd = 0; rnd < 60; rnd++) begin
      mask = 4'($urandom_range(1, 15));
      doclr = $urandom_range(0, 4) == 0;
      for (int i = 0; i < 4; i++)
        if (mask[i]) begin
          we_v[i] = 1'($urandom_range(0, 1));
          a_v[i] = 2'($urandom_range(0, 3));
          d_v[i] = 8'($urandom_range(0, 255));
          set_req(i, we_v[i], a_v[i], d_v[i]);
        end
      if (doclr) begin
        clr_req = 1'b1;
        for (int i = 0; i < 4; i++) mdl[i] = 0;
      end
      pend = mask;
      first = 1'b1;
      while (pend != 0) begin
        j = 0;
        for (int k = 3; k >= 0; k--) if (pend[(ptr + k) % 4]) j = (ptr + k) % 4;
        wait_gnt(g, rd, done);
        if (g == 0) break;
        if (first && doclr) chk("rand_clear_first", 32'(done), 1);
        first = 1'b0;
        chk("rand_gnt", 32'(g), 32'(1) << j);
        if (!we_v[j]) chk("rand_rd", 32'(rd), 32'(mdl[a_v[j]]));
        else mdl[a_v[j]] = int'(d_v[j]);
        ptr = (j + 1) % 4;
        pend[j] = 1'b0;
        @(posedge clk);
        #1 begin req[j] = 1'b0; clr_req = 1'b0; end
      end
      req = '0;
      clr_req = 1'b0;
    end

    // out-of-range address on a 3-register bank
    rst = 1'b0;
    rst3 = 1'b0;
    req = '0;
    sel3 = 1'b1;
    @(posedge clk);
    #1 rst3 = 1'b1;
    txn("c6_w0", 0, 1'b1, 2'd0, 8'h01, 8'h00);
    txn("c6_w1", 0, 1'b1, 2'd1, 8'h02, 8'h00);
    txn("c6_w2", 0, 1'b1, 2'd2, 8'h03, 8'h00);
    txn("c6_w3", 2, 1'b1, 2'd3, 8'hFF, 8'h00);
    txn("c6_r1", 2, 1'b0, 2'd1, 8'h00, 8'h02);
    txn("c6_r3", 2, 1'b0, 2'd3, 8'h00, 8'h00);
    txn("c6_r0", 1, 1'b0, 2'd0, 8'h00, 8'h01);
    txn("c6_r2", 3, 1'b0, 2'd2, 8'h00, 8'h03);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
